// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encodings and
// the default table depth.
package branch_predictor_pkg;

    localparam int unsigned BP_ENTRIES_DEFAULT = 16;

    typedef enum logic [1:0] {
        BP_STRONG_NT = 2'b00,
        BP_WEAK_NT   = 2'b01,
        BP_WEAK_T    = 2'b10,
        BP_STRONG_T  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and training port bundle between the pipeline (master) and the
// branch predictor (slave).
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        branch_estimation;
    logic [31:0] branch_target_estimated;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    modport master (
        output if_pc,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target,
        input  branch_estimation,
        input  branch_target_estimated
    );

    modport slave (
        input  if_pc,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target,
        output branch_estimation,
        output branch_target_estimated
    );

endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry. Lookup is
// combinational from the registered tables; EX-stage outcomes train them.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_ENTRIES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);

    localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [31:0]           target_d [ENTRIES];
    bp_ctr_e               ctr_q    [ENTRIES];
    bp_ctr_e               ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic [3:0]            unused_pc_bits;

    function automatic bp_ctr_e ctr_next(input bp_ctr_e c, input logic taken);
        ctr_next = c;
        case (c)
            BP_STRONG_NT: ctr_next = taken ? BP_WEAK_NT  : BP_STRONG_NT;
            BP_WEAK_NT:   ctr_next = taken ? BP_WEAK_T   : BP_STRONG_NT;
            BP_WEAK_T:    ctr_next = taken ? BP_STRONG_T : BP_WEAK_NT;
            BP_STRONG_T:  ctr_next = taken ? BP_STRONG_T : BP_WEAK_T;
            default:      ctr_next = c;
        endcase
    endfunction

    // Word-aligned PCs: the low two bits never select an entry.
    assign unused_pc_bits = {bp.if_pc[1:0], bp.update_pc[1:0]};

    always_comb begin
        lk_idx = bp.if_pc[INDEX_BITS+1:2];
        lk_tag = bp.if_pc[31:INDEX_BITS+2];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

        bp.branch_estimation       = lk_hit && ctr_q[lk_idx][1];
        bp.branch_target_estimated = bp.branch_estimation ? target_q[lk_idx]
                                                          : bp.if_pc + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        up_idx = bp.update_pc[INDEX_BITS+1:2];
        up_tag = bp.update_pc[31:INDEX_BITS+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

        if (bp.update_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = ctr_next(ctr_q[up_idx], bp.update_taken);
                if (bp.update_taken) begin
                    target_d[up_idx] = bp.update_target;
                end
            end else if (bp.update_taken) begin
                // Miss-taken allocates (and evicts any alias); miss-not-taken is ignored.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.update_target;
                ctr_d[up_idx]    = BP_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_WEAK_NT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each step drives a lookup plus an
// optional update, queues the expected lookup result, and checks it.
module tb_branch_predictor;

    logic clk;
    logic reset;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    typedef struct {
        logic        est;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // One cycle: drive at the negedge, check 1 unit later, then cross the posedge.
    task automatic cyc(input logic [31:0] lpc, input logic e_est, input logic [31:0] e_tgt,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic rst, input string name);
        exp_t e;
        reset     = rst;
        bp.if_pc  = lpc;
        bp.update_valid = uv;
        if (uv) begin
            bp.update_pc     = upc;
            bp.update_taken  = ut;
            bp.update_target = utgt;
        end else begin
            bp.update_pc     = 'x;
            bp.update_taken  = 1'bx;
            bp.update_target = 'x;
        end
        sb.push_back('{est: e_est, tgt: e_tgt, name: name});
        #1;
        e = sb.pop_front();
        total++;
        assert (bp.branch_estimation === e.est) else begin
            bad++;
            $error("FAIL %s.est: got %b want %b", e.name, bp.branch_estimation, e.est);
        end
        total++;
        assert (bp.branch_target_estimated === e.tgt) else begin
            bad++;
            $error("FAIL %s.tgt: got %h want %h", e.name, bp.branch_target_estimated, e.tgt);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic look(input logic [31:0] lpc, input logic e_est, input logic [31:0] e_tgt,
                        input string name);
        cyc(lpc, e_est, e_tgt, 1'b0, '0, 1'b0, '0, 1'b0, name);
    endtask

    task automatic upd(input logic [31:0] lpc, input logic e_est, input logic [31:0] e_tgt,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input string name);
        cyc(lpc, e_est, e_tgt, 1'b1, upc, ut, utgt, 1'b0, name);
    endtask

    initial begin
        reset = 1'b1;
        bp.if_pc = '0;
        bp.update_valid = 1'b0;
        bp.update_pc = '0;
        bp.update_taken = 1'b0;
        bp.update_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // post-reset
        look(32'h0000_1000, 1'b0, 32'h0000_1004, "rst_lookup");
        look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "rst_wrap");

        // allocation, no bypass
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b1, 32'h1100, "alloc_same_cycle");
        look(32'h1000, 1'b1, 32'h1100, "alloc_next");

        // hysteresis and saturation (ctr starts at 10)
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b1, 32'h1100, "t1");        // -> 11
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b1, 32'h1100, "t2_sat");    // stays 11
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b1, 32'h1100, "t3_sat");    // stays 11
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b0, 32'hDEAD_BEEC, "nt1");  // -> 10
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b0, 32'hDEAD_BEEC, "nt2");  // -> 01
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b0, 32'h0, "nt3");          // -> 00
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b0, 32'h0, "nt4_sat");      // stays 00
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b1, 32'h1100, "rt1");       // -> 01
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b1, 32'h1180, "rt2");       // -> 10
        look(32'h1000, 1'b1, 32'h1180, "retrained");

        // aliasing on index 0
        look(32'h1040, 1'b0, 32'h1044, "alias_miss");
        upd(32'h1000, 1'b1, 32'h1180, 32'h1040, 1'b0, 32'h2000, "alias_nt");
        look(32'h1000, 1'b1, 32'h1180, "alias_nt_kept");
        upd(32'h1040, 1'b0, 32'h1044, 32'h1040, 1'b1, 32'h2000, "alias_t");
        look(32'h1040, 1'b1, 32'h2000, "alias_new");
        look(32'h1000, 1'b0, 32'h1004, "alias_evicted");

        // reset interactions
        upd(32'h1004, 1'b0, 32'h1008, 32'h1004, 1'b1, 32'h3000, "idx1_alloc");
        look(32'h1004, 1'b1, 32'h3000, "idx1_hit");
        cyc(32'h1040, 1'b1, 32'h2000, 1'b1, 32'h1080, 1'b1, 32'h4000, 1'b1, "rst_with_upd");
        look(32'h1080, 1'b0, 32'h1084, "rst_drop_upd");
        look(32'h1040, 1'b0, 32'h1044, "rst_clr_idx0");
        look(32'h1004, 1'b0, 32'h1008, "rst_clr_idx1");
        upd(32'h1000, 1'b0, 32'h1004, 32'h1000, 1'b1, 32'h1100, "post_rst_alloc");
        look(32'h1000, 1'b1, 32'h1100, "post_rst_hit");
        upd(32'h1000, 1'b1, 32'h1100, 32'h1000, 1'b0, 32'h0, "post_rst_nt");  // 10 -> 01
        look(32'h1000, 1'b0, 32'h1004, "post_rst_weak_nt");

        // fill every index
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pc;
            logic [31:0] tgt;
            pc  = 32'(i * 4);
            tgt = 32'h8000 + 32'(i * 256);
            upd(32'hFFFF_FFFC, 1'b0, 32'h0, pc, 1'b1, tgt, $sformatf("fill_%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pc;
            logic [31:0] tgt;
            pc  = 32'(i * 4);
            tgt = 32'h8000 + 32'(i * 256);
            look(pc, 1'b1, tgt, $sformatf("fill_chk_%0d", i));
        end
        look(32'h1000, 1'b0, 32'h1004, "fill_evicted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
